// File: rtl/gfx128_pixel_fetch.sv
// Pixel/z read path: fetches one pixel (and optionally its depth) over a 128-bit read port.
// Optional depth comparator enabled by defining GFX_FETCH_ZTEST_EN.
module gfx128_pixel_fetch #(
    parameter int unsigned point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [27:0]            target_base_i,
    input  logic [27:0]            zbuffer_base_i,
    input  logic [point_width-1:0] target_size_x_i,
    input  logic [point_width-1:0] target_size_y_i,
    input  logic [1:0]             color_depth_i,
    input  logic                   zbuffer_enable_i,
    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic [point_width-1:0] pixel_z_i,
    input  logic                   read_i,
    output logic                   busy_o,
    output logic                   read_o,
    output logic [27:0]            fetch_addr_o,
    input  logic [127:0]           dat_i,
    input  logic                   ack_i,
    output logic                   valid_o,
    output logic [31:0]            color_o,
    output logic [15:0]            z_o,
    output logic                   oob_o,
    output logic                   z_pass_o
);

    typedef enum logic [1:0] {StIdle, StRdPix, StRdZ, StDone} state_e;

    state_e      state_q;
    logic        read_q, busy_q, valid_q, oob_q, zen_q;
    logic [27:0] addr_q, zaddr_q;
    logic [31:0] color_q, col_stage_q;
    logic [15:0] z_q;
    logic [1:0]  depth_q;
    logic [3:0]  lane_x_q;  // lane select only needs x[3:0]

    logic [31:0] idx, pix_off, z_off;
    logic [27:0] pix_addr, z_addr;
    logic        in_range;
    logic [31:0] pix_lane;
    logic [15:0] z_lane;

    // Addresses are computed from the live inputs on the accepting cycle and then held.
    always_comb begin
        idx = 32'(target_size_x_i) * 32'(pixel_y_i) + 32'(pixel_x_i);
        case (color_depth_i)
            2'b00:   pix_off = idx;
            2'b01:   pix_off = idx << 1;
            default: pix_off = idx << 2;
        endcase
        z_off    = idx << 1;
        pix_addr = target_base_i + pix_off[31:4];
        z_addr   = zbuffer_base_i + z_off[31:4];
        in_range = (pixel_x_i < target_size_x_i) && (pixel_y_i < target_size_y_i);
    end

    always_comb begin
        case (depth_q)
            2'b00:   pix_lane = 32'(dat_i[{lane_x_q, 3'b000} +: 8]);
            2'b01:   pix_lane = 32'(dat_i[{lane_x_q[2:0], 4'b0000} +: 16]);
            default: pix_lane = dat_i[{lane_x_q[1:0], 5'b00000} +: 32];
        endcase
        z_lane = dat_i[{lane_x_q[2:0], 4'b0000} +: 16];
    end

`ifdef GFX_FETCH_ZTEST_EN
    logic                   z_pass_q;
    logic [point_width-1:0] pz_q;
    assign z_pass_o = z_pass_q;
`else
    logic unused_pz;
    assign unused_pz = ^pixel_z_i;
    assign z_pass_o  = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            oob_q       <= 1'b0;
            zen_q       <= 1'b0;
            addr_q      <= '0;
            zaddr_q     <= '0;
            color_q     <= '0;
            col_stage_q <= '0;
            z_q         <= '0;
            depth_q     <= '0;
            lane_x_q    <= '0;
`ifdef GFX_FETCH_ZTEST_EN
            z_pass_q    <= 1'b1;
            pz_q        <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (read_i) begin
                        depth_q  <= color_depth_i;
                        zen_q    <= zbuffer_enable_i;
                        lane_x_q <= pixel_x_i[3:0];
                        zaddr_q  <= z_addr;
`ifdef GFX_FETCH_ZTEST_EN
                        pz_q     <= pixel_z_i;
`endif
                        if (!in_range) begin
                            state_q  <= StDone;
                            valid_q  <= 1'b1;
                            oob_q    <= 1'b1;
                            color_q  <= '0;
                            z_q      <= '0;
`ifdef GFX_FETCH_ZTEST_EN
                            z_pass_q <= 1'b0;
`endif
                        end else begin
                            state_q <= StRdPix;
                            read_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            addr_q  <= pix_addr;
                        end
                    end
                end
                StRdPix: begin
                    if (ack_i) begin
                        if (zen_q) begin
                            state_q     <= StRdZ;
                            col_stage_q <= pix_lane;
                            addr_q      <= zaddr_q;
                        end else begin
                            state_q  <= StDone;
                            read_q   <= 1'b0;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                            oob_q    <= 1'b0;
                            color_q  <= pix_lane;
                            z_q      <= '0;
`ifdef GFX_FETCH_ZTEST_EN
                            z_pass_q <= 1'b1;
`endif
                        end
                    end
                end
                StRdZ: begin
                    if (ack_i) begin
                        state_q  <= StDone;
                        read_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        oob_q    <= 1'b0;
                        color_q  <= col_stage_q;
                        z_q      <= z_lane;
`ifdef GFX_FETCH_ZTEST_EN
                        z_pass_q <= (16'(pz_q) < z_lane);
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign read_o       = read_q;
    assign fetch_addr_o = addr_q;
    assign valid_o      = valid_q;
    assign color_o      = color_q;
    assign z_o          = z_q;
    assign oob_o        = oob_q;

endmodule

// File: tb/tb_gfx128_pixel_fetch.sv
// Randomized bench for gfx128_pixel_fetch against an arithmetic reference model.
module tb_gfx128_pixel_fetch;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [27:0]  target_base_i, zbuffer_base_i;
    logic [15:0]  target_size_x_i, target_size_y_i;
    logic [1:0]   color_depth_i;
    logic         zbuffer_enable_i;
    logic [15:0]  pixel_x_i, pixel_y_i, pixel_z_i;
    logic         read_i;
    logic         busy_o, read_o;
    logic [27:0]  fetch_addr_o;
    logic [127:0] dat_i;
    logic         ack_i;
    logic         valid_o;
    logic [31:0]  color_o;
    logic [15:0]  z_o;
    logic         oob_o, z_pass_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned valid_cnt = 0;

    gfx128_pixel_fetch #(.point_width(16)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .target_base_i    (target_base_i),
        .zbuffer_base_i   (zbuffer_base_i),
        .target_size_x_i  (target_size_x_i),
        .target_size_y_i  (target_size_y_i),
        .color_depth_i    (color_depth_i),
        .zbuffer_enable_i (zbuffer_enable_i),
        .pixel_x_i        (pixel_x_i),
        .pixel_y_i        (pixel_y_i),
        .pixel_z_i        (pixel_z_i),
        .read_i           (read_i),
        .busy_o           (busy_o),
        .read_o           (read_o),
        .fetch_addr_o     (fetch_addr_o),
        .dat_i            (dat_i),
        .ack_i            (ack_i),
        .valid_o          (valid_o),
        .color_o          (color_o),
        .z_o              (z_o),
        .oob_o            (oob_o),
        .z_pass_o         (z_pass_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (valid_o === 1'b1) valid_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int unsigned bpp_bytes(input logic [1:0] dep);
        return (dep == 2'b00) ? 1 : (dep == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [27:0] model_addr(input logic [27:0] base, input int unsigned x,
                                               input int unsigned y, input int unsigned bytes);
        int unsigned idx = int'(target_size_x_i) * y + x;
        int unsigned off = idx * bytes;
        return base + 28'(off / 16);
    endfunction

    function automatic logic [31:0] model_lane(input logic [127:0] d, input int unsigned bytes,
                                               input int unsigned x);
        int unsigned lane = x % (16 / bytes);
        logic [127:0] s = d >> (lane * bytes * 8);
        if (bytes == 4) return s[31:0];
        if (bytes == 2) return {16'h0, s[15:0]};
        return {24'h0, s[7:0]};
    endfunction

    function automatic logic model_zpass(input bit oob, input logic zen, input logic [15:0] pz,
                                         input logic [15:0] z);
`ifdef GFX_FETCH_ZTEST_EN
        if (oob) return 1'b0;
        if (!zen) return 1'b1;
        return pz < z;
`else
        return 1'b1;
`endif
    endfunction

    task automatic rand_dat();
        dat_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One full fetch; inputs are scrambled after acceptance to prove they are latched.
    task automatic fetch(input int unsigned x, input int unsigned y, input logic [1:0] dep,
                         input logic zen, input logic [15:0] pz, input int unsigned dly,
                         input bit repulse);
        logic [127:0] pdat, zdat;
        logic [27:0]  paddr, zaddr;
        logic [31:0]  ecol;
        logic [15:0]  ez;
        int unsigned  cnt0, bytes;
        bit           oob;
        bytes = bpp_bytes(dep);
        oob   = (x >= int'(target_size_x_i)) || (y >= int'(target_size_y_i));
        paddr = model_addr(target_base_i, x, y, bytes);
        zaddr = model_addr(zbuffer_base_i, x, y, 2);
        cnt0  = valid_cnt;
        @(negedge clk_i);
        pixel_x_i = 16'(x); pixel_y_i = 16'(y); pixel_z_i = pz;
        color_depth_i = dep; zbuffer_enable_i = zen; read_i = 1'b1;
        @(negedge clk_i);
        read_i = 1'b0;
        pixel_x_i = 16'($urandom); pixel_z_i = 16'($urandom);
        color_depth_i = 2'($urandom); zbuffer_enable_i = 1'($urandom);
        zbuffer_base_i = 28'($urandom); target_base_i = 28'($urandom);
        if (oob) begin
            check_eq("oob_read", 32'(read_o), 0);
            check_eq("oob_valid", 32'(valid_o), 1);
            check_eq("oob_flag", 32'(oob_o), 1);
            check_eq("oob_color", color_o, 0);
            check_eq("oob_z", 32'(z_o), 0);
            check_eq("oob_zpass", 32'(z_pass_o), 32'(model_zpass(1, zen, pz, 0)));
        end else begin
            check_eq("busy", 32'(busy_o), 1);
            check_eq("read_rise", 32'(read_o), 1);
            check_eq("pix_addr", 32'(fetch_addr_o), 32'(paddr));
            for (int i = 0; i < int'(dly); i++) begin
                if (repulse && i == 0) read_i = 1'b1;
                @(negedge clk_i);
                read_i = 1'b0;
                check_eq("pix_hold", 32'(fetch_addr_o), 32'(paddr));
            end
            rand_dat(); pdat = dat_i; ack_i = 1'b1;
            @(negedge clk_i);
            ack_i = 1'b0; rand_dat();
            ecol = model_lane(pdat, bytes, x);
            ez   = 16'h0;
            if (zen) begin
                check_eq("z_read", 32'(read_o), 1);
                check_eq("z_addr", 32'(fetch_addr_o), 32'(zaddr));
                check_eq("z_novalid", 32'(valid_o), 0);
                for (int i = 0; i < int'(dly); i++) @(negedge clk_i);
                rand_dat(); zdat = dat_i; ack_i = 1'b1;
                @(negedge clk_i);
                ack_i = 1'b0; rand_dat();
                ez = 16'(model_lane(zdat, 2, x));
            end
            check_eq("valid", 32'(valid_o), 1);
            check_eq("read_done", 32'(read_o), 0);
            check_eq("busy_done", 32'(busy_o), 0);
            check_eq("oob_clear", 32'(oob_o), 0);
            check_eq("color", color_o, ecol);
            check_eq("z", 32'(z_o), 32'(ez));
            check_eq("zpass", 32'(z_pass_o), 32'(model_zpass(0, zen, pz, ez)));
        end
        @(negedge clk_i);
        #1;
        check_eq("valid_pulse", 32'(valid_o), 0);
        check_eq("valid_count", valid_cnt - cnt0, 1);
        if (!oob) check_eq("color_hold", color_o, ecol);
    endtask

    task automatic set_target(input int unsigned sx, input int unsigned sy,
                              input logic [27:0] tb, input logic [27:0] zb);
        target_size_x_i = 16'(sx); target_size_y_i = 16'(sy);
        target_base_i = tb; zbuffer_base_i = zb;
    endtask

    initial begin
        int unsigned sx, sy, cnt0;
        rst_i = 1'b1; read_i = 1'b0; ack_i = 1'b0; dat_i = '0;
        pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0;
        color_depth_i = '0; zbuffer_enable_i = 1'b0;
        set_target(640, 480, 28'h10000, 28'h20000);
        @(negedge clk_i);
        check_eq("rst_read", 32'(read_o), 0);
        check_eq("rst_valid", 32'(valid_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_oob", 32'(oob_o), 0);
        check_eq("rst_addr", 32'(fetch_addr_o), 0);
        check_eq("rst_color", color_o, 0);
        check_eq("rst_z", 32'(z_o), 0);
        check_eq("rst_zpass", 32'(z_pass_o), 1);
        rst_i = 1'b0;

        fetch(5, 2, 2'b01, 1'b0, 16'h0, 2, 0);
        set_target(640, 480, 28'h10000, 28'h20000);
        fetch(5, 2, 2'b01, 1'b1, 16'h00FF, 2, 0);
        set_target(640, 480, 28'h10000, 28'h20000);
        fetch(640, 0, 2'b01, 1'b1, 16'h0, 0, 0);
        set_target(640, 480, 28'h10000, 28'h20000);
        fetch(15, 0, 2'b00, 1'b0, 16'h0, 0, 0);
        set_target(640, 480, 28'h10000, 28'h20000);
        fetch(3, 7, 2'b10, 1'b0, 16'h0, 1, 0);
        set_target(640, 480, 28'h10000, 28'h20000);
        fetch(9, 4, 2'b11, 1'b1, 16'hFFFF, 3, 1);
        set_target(640, 480, 28'h10000, 28'h20000);
        fetch(0, 480, 2'b00, 1'b0, 16'h0, 0, 0);

        // Reset while a read is outstanding must drop read_o at once and lose the result.
        set_target(640, 480, 28'h10000, 28'h20000);
        cnt0 = valid_cnt;
        @(negedge clk_i);
        pixel_x_i = 16'd10; pixel_y_i = 16'd3; color_depth_i = 2'b10; read_i = 1'b1;
        @(negedge clk_i);
        read_i = 1'b0;
        check_eq("pre_rst_read", 32'(read_o), 1);
        #2 rst_i = 1'b1;
        #1 check_eq("async_rst_read", 32'(read_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0; ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 check_eq("rst_no_valid", valid_cnt - cnt0, 0);
        fetch(10, 3, 2'b10, 1'b0, 16'h0, 1, 0);

        for (int n = 0; n < 200; n++) begin
            if (n % 8 == 0) begin
                sx = $urandom_range(1, 800);
                sy = $urandom_range(1, 600);
                set_target(sx, sy, 28'($urandom), 28'($urandom));
            end else begin
                set_target(sx, sy, 28'($urandom), 28'($urandom));
            end
            fetch($urandom_range(0, sx + 2), $urandom_range(0, sy + 2), 2'($urandom),
                  1'($urandom), 16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
